// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
//   Sequencer for one SDFFS scan chain: serially loads PAT_IN (MSB first),
//   issues a single functional capture clock, then unloads the chain into RESP.
//
// Ports
//   CK      clock, all state changes on the rising edge
//   RST     asynchronous active-high reset
//   START   begin a load/capture/unload sequence (honoured in IDLE only)
//   ABORT   synchronous abort back to IDLE from any non-IDLE state
//   PRESET  in IDLE, pulse the chain set line SN low for one cycle
//   PAT_IN  pattern to load, captured on the edge that accepts START
//   SO      scan-out of the last chain flop
//   SE      scan enable to the chain
//   SI      scan-in to the first chain flop
//   SN      active-low set to the chain
//   RESP    unloaded response, RESP[j] lines up with PAT_IN[j]
//   BUSY    high during LOAD, CAPTURE and UNLOAD
//   DONE    one-cycle completion pulse
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CW        = $clog2(CHAIN_LEN)
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 PRESET,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 SN,
  output logic [CHAIN_LEN-1:0] RESP,
  output logic                 BUSY,
  output logic                 DONE
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(CHAIN_LEN - 1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0]   pat_q, pat_d;
  logic [CHAIN_LEN-1:0]   resp_q, resp_d;
  logic                   se_q, se_d;
  logic                   si_q, si_d;
  logic                   sn_q, sn_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Outputs are registered and describe the cycle being entered, so each
  // branch below sets the values that must appear right after this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    resp_d  = resp_q;
    se_d    = 1'b0;
    si_d    = 1'b0;
    sn_d    = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) begin
          // First bit goes straight onto SI; the register keeps the rest.
          si_d    = PAT_IN[CHAIN_LEN-1];
          pat_d   = {PAT_IN[CHAIN_LEN-2:0], 1'b0};
          se_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else if (PRESET) begin
          sn_d = 1'b0;
        end
      end

      ST_LOAD: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Last shift edge: next cycle is the capture with SE=0, SI=0.
          state_d = ST_CAPTURE;
        end else begin
          se_d  = 1'b1;
          si_d  = pat_q[CHAIN_LEN-1];
          pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
        end
      end

      ST_CAPTURE: begin
        busy_d  = 1'b1;
        se_d    = 1'b1;
        cnt_d   = '0;
        state_d = ST_UNLOAD;
      end

      ST_UNLOAD: begin
        // SO is sampled on the same edge that shifts the chain.
        resp_d = {resp_q[CHAIN_LEN-2:0], SO};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          se_d   = 1'b1;
          busy_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every active state; RESP keeps whatever it has so far.
    if (ABORT && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pat_d   = pat_q;
      resp_d  = resp_q;
      se_d    = 1'b0;
      si_d    = 1'b0;
      sn_d    = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      resp_q  <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      sn_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      resp_q  <= resp_d;
      se_q    <= se_d;
      si_q    <= si_d;
      sn_q    <= sn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SE   = se_q;
  assign SI   = si_q;
  assign SN   = sn_q;
  assign RESP = resp_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
